// File: rtl/spi_target_controller_pkg.sv
// Shared types and constants for the SPI target controller and its shifter.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);
    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE_DFLT = 8'hFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_tgt_state_e;

    typedef struct packed {
        logic rise;
        logic fall;
    } spi_edge_t;

    function automatic spi_edge_t spi_edge(input logic cur, input logic prev);
        spi_edge_t e;
        e.rise = cur & ~prev;
        e.fall = ~cur & prev;
        return e;
    endfunction

endpackage

// File: rtl/spi_target_controller_if.sv
// Host-side byte bus of the SPI target controller (TX/RX FIFO access and status).
interface spi_target_controller_if;
    import spi_pkg::*;

    logic                  i_wr;
    logic [SPI_BYTE_W-1:0] i_din;
    logic                  i_rd;
    logic                  i_clr_flags;
    logic [SPI_BYTE_W-1:0] o_dout;
    logic                  o_data_avail;
    logic                  o_tx_empty;
    logic                  o_tx_full;
    logic                  o_busy;
    logic                  o_underflow;
    logic                  o_overflow;

    modport slave (
        input  i_wr, i_din, i_rd, i_clr_flags,
        output o_dout, o_data_avail, o_tx_empty, o_tx_full, o_busy, o_underflow, o_overflow
    );

    modport master (
        output i_wr, i_din, i_rd, i_clr_flags,
        input  o_dout, o_data_avail, o_tx_empty, o_tx_full, o_busy, o_underflow, o_overflow
    );

endinterface

// File: rtl/spi_target_controller_fifo.sv
// Standard synchronous FIFO; head is visible combinationally, status derives from a registered count.
module spi_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = r_count[DEPTH_LOG2];
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_target_controller_shifter.sv
// Oversampled SPI target shifter: pin synchronizers, edge detect, bit counter, shift registers, FSM.
// SPI_TGT_MODE_SEL_EN adds i_cpol/i_cpha; without it the shifter is fixed to mode 0.
module spi_target_shifter
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE = SPI_FILL_BYTE_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sck,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
`ifdef SPI_TGT_MODE_SEL_EN
    input  logic                  i_cpol,
    input  logic                  i_cpha,
`endif
    input  logic                  i_tx_empty,
    input  logic [SPI_BYTE_W-1:0] i_tx_byte,
    output logic                  o_tx_load_req,
    output logic                  o_underflow_set,
    output logic                  o_rx_push,
    output logic [SPI_BYTE_W-1:0] o_rx_byte,
    output logic                  o_busy,
    output logic                  o_miso,
    output logic                  o_miso_oe
);

    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);
    localparam logic [SPI_CNT_W-1:0] CNT_ONE  = 1;

    logic [2:0]            r_sck_s;
    logic [1:0]            r_cs_s;
    logic                  r_cs_prev;
    logic [1:0]            r_mosi_s;
    spi_tgt_state_e        r_state;
    logic [SPI_CNT_W-1:0]  r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_tx_sr;
    logic [SPI_BYTE_W-2:0] r_rx_sr;
    logic                  r_fill_pend;

    spi_tgt_state_e        w_state_nx;
    logic [SPI_CNT_W-1:0]  w_bit_cnt_nx;
    logic [SPI_BYTE_W-1:0] w_tx_sr_nx;
    logic [SPI_BYTE_W-2:0] w_rx_sr_nx;
    logic                  w_fill_pend_nx;
    logic                  w_load;
    logic                  w_under;
    logic                  w_push;
    spi_edge_t             w_sck_e;
    spi_edge_t             w_cs_e;
    logic                  w_mosi;
    logic                  w_cpol;
    logic                  w_cpha;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_drive;

`ifdef SPI_TGT_MODE_SEL_EN
    assign w_cpol = i_cpol;
    assign w_cpha = i_cpha;
`else
    assign w_cpol = 1'b0;
    assign w_cpha = 1'b0;
`endif

    assign w_sck_e  = spi_edge(r_sck_s[1], r_sck_s[2]);
    assign w_cs_e   = spi_edge(r_cs_s[1], r_cs_prev);
    assign w_mosi   = r_mosi_s[1];
    assign w_lead   = w_cpol ? w_sck_e.fall : w_sck_e.rise;
    assign w_trail  = w_cpol ? w_sck_e.rise : w_sck_e.fall;
    assign w_sample = w_cpha ? w_trail : w_lead;
    assign w_drive  = w_cpha ? w_lead : w_trail;

    // Reloads happen right after the 8th sample; a FILL_BYTE reload only counts as
    // underflow once the master actually starts clocking that byte.
    always_comb begin
        w_state_nx     = r_state;
        w_bit_cnt_nx   = r_bit_cnt;
        w_tx_sr_nx     = r_tx_sr;
        w_rx_sr_nx     = r_rx_sr;
        w_fill_pend_nx = r_fill_pend;
        w_load         = 1'b0;
        w_under        = 1'b0;
        w_push         = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_bit_cnt_nx   = '0;
                w_fill_pend_nx = 1'b0;
                if (w_cs_e.fall) begin
                    w_state_nx = SHIFT;
                    if (!w_cpha) begin
                        w_load  = 1'b1;
                        w_under = i_tx_empty;
                    end
                end
            end
            SHIFT: begin
                if (w_cs_e.rise) begin
                    w_state_nx     = IDLE;
                    w_bit_cnt_nx   = '0;
                    w_fill_pend_nx = 1'b0;
                end else if (w_sample) begin
                    w_rx_sr_nx = {r_rx_sr[SPI_BYTE_W-3:0], w_mosi};
                    if (r_bit_cnt == '0 && r_fill_pend) begin
                        w_under        = 1'b1;
                        w_fill_pend_nx = 1'b0;
                    end
                    if (r_bit_cnt == LAST_BIT) begin
                        w_push       = 1'b1;
                        w_bit_cnt_nx = '0;
                        if (!w_cpha) begin
                            w_load         = 1'b1;
                            w_fill_pend_nx = i_tx_empty;
                        end
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + CNT_ONE;
                    end
                end else if (w_drive) begin
                    if (r_bit_cnt == '0) begin
                        if (w_cpha) begin
                            w_load  = 1'b1;
                            w_under = i_tx_empty;
                        end
                    end else begin
                        w_tx_sr_nx = {r_tx_sr[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
        endcase
        if (w_load) begin
            w_tx_sr_nx = i_tx_empty ? FILL_BYTE : i_tx_byte;
        end
    end

    // cs_n synchronizer resets low so a cs_n held low across reset never looks like a new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_s     <= '0;
            r_cs_s      <= '0;
            r_cs_prev   <= 1'b0;
            r_mosi_s    <= '0;
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_fill_pend <= 1'b0;
        end else begin
            r_sck_s     <= {r_sck_s[1:0], i_sck};
            r_cs_s      <= {r_cs_s[0], i_cs_n};
            r_cs_prev   <= r_cs_s[1];
            r_mosi_s    <= {r_mosi_s[0], i_mosi};
            r_state     <= w_state_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_tx_sr     <= w_tx_sr_nx;
            r_rx_sr     <= w_rx_sr_nx;
            r_fill_pend <= w_fill_pend_nx;
        end
    end

    assign o_tx_load_req   = w_load;
    assign o_underflow_set = w_under;
    assign o_rx_push       = w_push;
    assign o_rx_byte       = {r_rx_sr, w_mosi};
    assign o_busy          = (r_state == SHIFT);
    assign o_miso_oe       = (r_state == SHIFT);
    assign o_miso          = r_tx_sr[SPI_BYTE_W-1];

endmodule

// File: rtl/spi_target_controller.sv
// SPI target endpoint: shifter plus TX/RX byte FIFOs and sticky underflow/overflow flags.
// SPI_TGT_MODE_SEL_EN adds i_cpol/i_cpha mode-select ports; default build is mode 0 only.
module spi_target_controller
    import spi_pkg::*;
#(
    parameter int                    DEPTH_LOG2 = 4,
    parameter logic [SPI_BYTE_W-1:0] FILL_BYTE  = SPI_FILL_BYTE_DFLT
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_target_controller_if.slave       bus,
    input  logic                         i_sck,
    input  logic                         i_cs_n,
    input  logic                         i_mosi,
`ifdef SPI_TGT_MODE_SEL_EN
    input  logic                         i_cpol,
    input  logic                         i_cpha,
`endif
    output logic                         o_miso,
    output logic                         o_miso_oe
);

    logic [SPI_BYTE_W-1:0] w_tx_head;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic                  w_tx_load;
    logic                  w_under_set;
    logic                  w_rx_push;
    logic [SPI_BYTE_W-1:0] w_rx_byte;
    logic [SPI_BYTE_W-1:0] w_rx_head;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_rx_pop;
    logic                  w_over_set;
    logic                  w_busy;
    logic [SPI_BYTE_W-1:0] r_dout;
    logic                  r_underflow;
    logic                  r_overflow;

    spi_target_shifter #(
        .FILL_BYTE (FILL_BYTE)
    ) u_shifter (
        .clk             (clk),
        .rst             (rst),
        .i_sck           (i_sck),
        .i_cs_n          (i_cs_n),
        .i_mosi          (i_mosi),
`ifdef SPI_TGT_MODE_SEL_EN
        .i_cpol          (i_cpol),
        .i_cpha          (i_cpha),
`endif
        .i_tx_empty      (w_tx_empty),
        .i_tx_byte       (w_tx_head),
        .o_tx_load_req   (w_tx_load),
        .o_underflow_set (w_under_set),
        .o_rx_push       (w_rx_push),
        .o_rx_byte       (w_rx_byte),
        .o_busy          (w_busy),
        .o_miso          (o_miso),
        .o_miso_oe       (o_miso_oe)
    );

    spi_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (SPI_BYTE_W)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.i_wr),
        .i_data  (bus.i_din),
        .i_pop   (w_tx_load),
        .o_head  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    spi_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (SPI_BYTE_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (w_rx_byte),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    assign w_rx_pop   = bus.i_rd & ~w_rx_empty;
    assign w_over_set = w_rx_push & w_rx_full & ~w_rx_pop;

    // A new error in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_rx_pop) begin
                r_dout <= w_rx_head;
            end
            r_underflow <= w_under_set | (r_underflow & ~bus.i_clr_flags);
            r_overflow  <= w_over_set | (r_overflow & ~bus.i_clr_flags);
        end
    end

    assign bus.o_dout       = r_dout;
    assign bus.o_data_avail = ~w_rx_empty;
    assign bus.o_tx_empty   = w_tx_empty;
    assign bus.o_tx_full    = w_tx_full;
    assign bus.o_busy       = w_busy;
    assign bus.o_underflow  = r_underflow;
    assign bus.o_overflow   = r_overflow;

endmodule

// File: tb/tb_spi_target_controller.sv
// Directed plus randomized bench for spi_target_controller in mode 0 against a queue-based model.
module tb_spi_target_controller;

    logic clk = 1'b0;
    logic rst;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;
`ifdef SPI_TGT_MODE_SEL_EN
    logic cpol = 1'b0;
    logic cpha = 1'b0;
`endif

    spi_target_controller_if bus();

    spi_target_controller #(
        .DEPTH_LOG2 (4),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .i_sck     (sck),
        .i_cs_n    (cs_n),
        .i_mosi    (mosi),
`ifdef SPI_TGT_MODE_SEL_EN
        .i_cpol    (cpol),
        .i_cpha    (cpha),
`endif
        .o_miso    (miso),
        .o_miso_oe (miso_oe)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: FIFO contents as queues, sticky flags as bits.
    logic [7:0] m_tx [$];
    logic [7:0] m_rx [$];
    logic       m_under;
    logic       m_over;
    logic [7:0] f_mosi [$];

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic half_bit();
        repeat (8) @(negedge clk);
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_under = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] b);
        @(negedge clk);
        bus.i_wr  = 1'b1;
        bus.i_din = b;
        @(negedge clk);
        bus.i_wr  = 1'b0;
        if (m_tx.size() < 16) m_tx.push_back(b);
    endtask

    task automatic host_read(input string tag);
        logic [7:0] exp;
        check1({tag, " data_avail"}, bus.o_data_avail, 1'b1);
        @(negedge clk);
        bus.i_rd = 1'b1;
        @(negedge clk);
        bus.i_rd = 1'b0;
        exp = m_rx.pop_front();
        check8({tag, " dout"}, bus.o_dout, exp);
    endtask

    task automatic host_clr(input string tag);
        @(negedge clk);
        bus.i_clr_flags = 1'b1;
        @(negedge clk);
        bus.i_clr_flags = 1'b0;
        m_under = 1'b0;
        m_over  = 1'b0;
        check1({tag, " underflow"}, bus.o_underflow, 1'b0);
        check1({tag, " overflow"}, bus.o_overflow, 1'b0);
    endtask

    task automatic check_status(input string tag);
        check1({tag, " tx_empty"}, bus.o_tx_empty, m_tx.size() == 0);
        check1({tag, " tx_full"}, bus.o_tx_full, m_tx.size() == 16);
        check1({tag, " data_avail"}, bus.o_data_avail, m_rx.size() != 0);
        check1({tag, " underflow"}, bus.o_underflow, m_under);
        check1({tag, " overflow"}, bus.o_overflow, m_over);
    endtask

    task automatic check_reset_vals(input string tag);
        check8({tag, " dout"}, bus.o_dout, 8'h00);
        check1({tag, " miso"}, miso, 1'b0);
        check1({tag, " miso_oe"}, miso_oe, 1'b0);
        check1({tag, " busy"}, bus.o_busy, 1'b0);
        check1({tag, " underflow"}, bus.o_underflow, 1'b0);
        check1({tag, " overflow"}, bus.o_overflow, 1'b0);
        check1({tag, " tx_empty"}, bus.o_tx_empty, 1'b1);
        check1({tag, " data_avail"}, bus.o_data_avail, 1'b0);
    endtask

    // Mode 0 master: present mosi, sample miso just before the rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            half_bit();
            mi = {mi[6:0], miso};
            sck = 1'b1;
            half_bit();
            sck = 1'b0;
        end
    endtask

    // One cs_n frame of nbytes full bytes from f_mosi, then optionally a partial byte.
    task automatic frame(input int nbytes, input int partial, input string tag);
        logic [7:0] got;
        logic [7:0] exp_cur;
        logic       pend;
        pend = 1'b0;
        if (m_tx.size() == 0) begin
            exp_cur = 8'hFF;
            m_under = 1'b1;
        end else begin
            exp_cur = m_tx.pop_front();
        end
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        check1({tag, " busy in frame"}, bus.o_busy, 1'b1);
        check1({tag, " miso_oe in frame"}, miso_oe, 1'b1);
        for (int k = 0; k < nbytes; k++) begin
            if (pend) m_under = 1'b1;
            spi_bits(f_mosi[k], 8, got);
            check8($sformatf("%s miso byte %0d", tag, k), got, exp_cur);
            if (m_rx.size() < 16) m_rx.push_back(f_mosi[k]);
            else m_over = 1'b1;
            if (m_tx.size() == 0) begin
                exp_cur = 8'hFF;
                pend    = 1'b1;
            end else begin
                exp_cur = m_tx.pop_front();
                pend    = 1'b0;
            end
        end
        if (partial > 0) begin
            if (pend) m_under = 1'b1;
            spi_bits(8'($urandom()), partial, got);
        end
        half_bit();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check1({tag, " miso_oe after frame"}, miso_oe, 1'b0);
        check1({tag, " busy after frame"}, bus.o_busy, 1'b0);
    endtask

    initial begin
        logic [7:0] junk;
        int         np;
        int         nb;

        rst             = 1'b1;
        sck             = 1'b0;
        cs_n            = 1'b1;
        mosi            = 1'b0;
        bus.i_wr        = 1'b0;
        bus.i_din       = 8'h00;
        bus.i_rd        = 1'b0;
        bus.i_clr_flags = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_status("post reset");

        // Single byte exchange
        host_push(8'hA5);
        check1("t1 tx_empty after push", bus.o_tx_empty, 1'b0);
        f_mosi = '{8'h3C};
        frame(1, 0, "t1");
        check_status("t1");
        host_read("t1 rd");

        // Empty TX sends fill bytes
        f_mosi = '{8'($urandom()), 8'($urandom())};
        frame(2, 0, "t2");
        check_status("t2");
        host_clr("t2 clr");
        host_read("t2 rd0");
        host_read("t2 rd1");

        // Back-to-back burst
        host_push(8'h01);
        host_push(8'h02);
        host_push(8'h03);
        f_mosi = '{8'h10, 8'h20, 8'h30};
        frame(3, 0, "t3");
        check_status("t3");
        for (int i = 0; i < 3; i++) host_read($sformatf("t3 rd%0d", i));
        check_status("t3 drained");

        // RX overflow
        f_mosi.delete();
        for (int i = 0; i < 16; i++) f_mosi.push_back(8'($urandom()));
        frame(16, 0, "t4 fill");
        check_status("t4 fill");
        f_mosi = '{8'h77};
        frame(1, 0, "t4 extra");
        check_status("t4 extra");
        for (int i = 0; i < 16; i++) host_read($sformatf("t4 rd%0d", i));
        check_status("t4 drained");
        host_clr("t4 clr");

        // Aborted partial byte, then a full byte
        host_push(8'($urandom()));
        f_mosi.delete();
        frame(0, 4, "t5 abort");
        check_status("t5 abort");
        f_mosi = '{8'h5A};
        frame(1, 0, "t5 full");
        check_status("t5 full");
        host_read("t5 rd");
        check_status("t5 drained");
        host_clr("t5 clr");

        // Asynchronous reset in the middle of bit 5
        host_push(8'($urandom()));
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'($urandom()), 4, junk);
        mosi = 1'b1;
        half_bit();
        sck = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("mid-frame reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sck = 1'b0;
        spi_bits(8'($urandom()), 8, junk);
        check1("t6 busy with stale cs_n", bus.o_busy, 1'b0);
        check1("t6 miso_oe with stale cs_n", miso_oe, 1'b0);
        check_status("t6 stale cs_n");
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        host_push(8'hC3);
        f_mosi = '{8'($urandom())};
        frame(1, 0, "t6 restart");
        check_status("t6 restart");
        host_read("t6 rd");

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            np = int'($urandom_range(0, 4));
            nb = int'($urandom_range(1, 3));
            for (int i = 0; i < np; i++) host_push(8'($urandom()));
            f_mosi.delete();
            for (int i = 0; i < nb; i++) f_mosi.push_back(8'($urandom()));
            frame(nb, 0, $sformatf("rand%0d", it));
            check_status($sformatf("rand%0d", it));
            while (m_rx.size() > 0) host_read($sformatf("rand%0d rd", it));
            if ($urandom_range(0, 1) == 1) host_clr($sformatf("rand%0d clr", it));
            check_status($sformatf("rand%0d end", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_target_controller.md
Name: spi_target_controller

Overview:
- SPI target (slave) endpoint: an external SPI master drives sck/cs_n/mosi, and this block answers on miso.
- Host side is byte-oriented, with a TX FIFO holding bytes to shift out and an RX FIFO holding bytes shifted in; it pairs with the existing master-side controller on the same mmio bus.
- External pins are sampled in the clk domain through synchronizers (oversampling); there is no sck-clocked logic.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).
- FILL_BYTE, 8'hFF, byte transmitted when the TX FIFO is empty at a byte boundary.

Ports:
- clk  in  1  system clock; must satisfy f_clk >= 8*f_sck.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  push din into TX FIFO; ignored when tx_full.
- din  in  8  TX byte.
- rd  in  1  pop RX FIFO; ignored when !data_avail.
- dout  out  8  byte popped by the last accepted rd.
- data_avail  out  1  RX FIFO not empty.
- tx_empty / tx_full  out  1  TX FIFO status.
- busy  out  1  synchronized cs_n low (transaction active).
- underflow  out  1  sticky: FILL_BYTE was sent.
- overflow  out  1  sticky: received byte dropped because RX FIFO full.
- clr_flags  in  1  clears underflow/overflow.
- sck, cs_n, mosi  in  1  external SPI pins (asynchronous).
- miso  out  1  serial data to master.
- miso_oe  out  1  tristate enable for the pad; high only while busy.

Behaviour:
- Reset values: dout=0, miso=0, miso_oe=0, busy=0, underflow=0, overflow=0; both FIFOs empty, so tx_empty=1, data_avail=0.
- Synchronization: sck, cs_n and mosi each pass through a 2-flop synchronizer, and a third flop on sck feeds edge detection. Edge pulses therefore arrive 2-3 clk after the pin edge.
- Default mode is SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- FSM IDLE (cs_n high):
  - miso_oe=0, bit_cnt=0.
  - On synchronized cs_n fall: load the TX shift register from the TX FIFO head (pop), or with FILL_BYTE and set underflow if empty. Drive miso=bit7, miso_oe=1, go to SHIFT.
- FSM SHIFT:
  - On rising sck edge: shift synchronized mosi into rx_sr LSB, bit_cnt++.
  - On falling sck edge: shift tx_sr left; miso = new MSB.
  - When bit_cnt reaches 8 (on the rising edge):
    - Push rx byte to RX FIFO; if full, drop it and set overflow.
    - bit_cnt wraps to 0.
    - Reload tx_sr from FIFO/FILL_BYTE on the same cycle. miso then shows the next bit7 while sck is still high, which is legal in mode 0.
    - The following falling edge does not shift.
- cs_n rise mid-byte (synchronized): discard partial rx bits (no push). The TX byte already popped is lost, not requeued. Clear bit_cnt, set miso_oe=0, return to IDLE.
- Simultaneous events:
  - Host wr and internal pop in the same cycle are both honoured; a pop from a full FIFO allows the wr.
  - Host rd and internal push in the same cycle are both honoured; a push into an empty FIFO followed by rd in the same cycle is not visible until next cycle (data_avail registered).
  - clr_flags in the same cycle as a new error: the set wins.
- dout updates on the clk edge where rd && data_avail, giving 1-cycle latency. dout holds otherwise.
- Reset mid-transaction: all state clears immediately. After reset release, a still-low cs_n is ignored until it rises and falls again: the FSM waits for a cs_n rising edge first.

Optional Feature:
- Macro: SPI_TGT_MODE_SEL_EN.
- Defined: adds input ports cpol and cpha (1 bit each, static while busy).
  - Sample edge = leading edge when cpha=0, trailing edge when cpha=1; leading edge is rising if cpol=0.
  - With cpha=1, the first bit is driven on the first leading edge, not at cs_n fall, and the reload at bit 8 is deferred to the next leading edge.
- Undefined: ports absent; fixed mode 0 as above.

Decomposition:
- Package spi_pkg holds:
  - spi_tgt_state_e enum (IDLE, SHIFT);
  - SPI_BYTE_W = 8;
  - default FILL_BYTE constant;
  - edge-detect struct {rise, fall}.
- Sub-module spi_target_shifter: synchronizers, edge detect, bit counter, tx/rx shift registers, FSM. It exposes tx_load_req/tx_byte and rx_push/rx_byte.
- The top instantiates the shifter plus two instances of the team's standard synchronous FIFO (DEPTH_LOG2, width 8) and the sticky flag logic.

Test Plan:
- Preload TX 8'hA5, master sends 8'h3C in mode 0 -> master receives 8'hA5; data_avail=1; rd -> dout=8'h3C next cycle; underflow=0.
- TX empty, master clocks 2 bytes -> master receives 8'hFF,8'hFF; underflow=1; clr_flags -> underflow=0.
- Back-to-back 3-byte burst with TX {8'h01,8'h02,8'h03}, RX from master {8'h10,8'h20,8'h30} -> master sees 01,02,03; RX FIFO holds 10,20,30 in order; tx_empty=1 at end.
- Fill RX with 16 bytes without rd, master sends a 17th byte 8'h77 -> overflow=1; first 16 bytes intact; 8'h77 absent.
- cs_n deasserted after 4 bits, then a full byte 8'h5A -> only 8'h5A pushed; miso_oe=0 between frames.
- Async rst pulse during bit 5 -> all outputs at reset values within the same cycle; the next frame starts only after cs_n high then low.
